// File: rtl/joy_dir_pkg.sv
// Shared types and helpers for the joystick direction filter.
package joy_dir_pkg;

    typedef enum logic [1:0] {
        JM_PASS  = 2'd0,
        JM_FOUR  = 2'd1,
        JM_TWO_H = 2'd2,
        JM_TWO_V = 2'd3
    } joy_mode_e;

    localparam int unsigned DIR_UP    = 3;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_RIGHT = 0;

    function automatic logic [3:0] allowed_mask(joy_mode_e m);
        case (m)
            JM_TWO_H: allowed_mask = 4'b0011;
            JM_TWO_V: allowed_mask = 4'b1100;
            default:  allowed_mask = 4'b1111;
        endcase
    endfunction

    // One-hot of the highest set bit: up > down > left > right.
    function automatic logic [3:0] pick_hi(logic [3:0] v);
        pick_hi = '0;
        if (v[DIR_UP])         pick_hi[DIR_UP]    = 1'b1;
        else if (v[DIR_DOWN])  pick_hi[DIR_DOWN]  = 1'b1;
        else if (v[DIR_LEFT])  pick_hi[DIR_LEFT]  = 1'b1;
        else if (v[DIR_RIGHT]) pick_hi[DIR_RIGHT] = 1'b1;
    endfunction

endpackage

// File: rtl/joy_dir_filter_if.sv
// Flat joystick buses between the hps_io side and the filter.
interface joy_dir_filter_if #(
    parameter int unsigned NUM_PLAYERS = 2
);
    logic [4*NUM_PLAYERS-1:0] dir_in;
    logic [2*NUM_PLAYERS-1:0] mode;
    logic [4*NUM_PLAYERS-1:0] dir_out;

    modport master (output dir_in, output mode, input dir_out);
    modport slave  (input dir_in, input mode, output dir_out);
endinterface

// File: rtl/joy_dir_chan.sv
// One player channel: input sync, optional per-bit debounce, direction arbitration.
module joy_dir_chan
    import joy_dir_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic      clk_sys,
    input  logic      reset,
    input  logic [3:0] i_dir,
    input  joy_mode_e i_mode,
    output logic [3:0] o_dir
);

    logic [3:0] r_raw;
    logic [3:0] r_prev;
    logic [3:0] r_act;
    joy_mode_e  r_mode_q;

    logic [3:0] w_db;
    logic [3:0] w_allowed;
    logic [3:0] w_h;
    logic [3:0] w_press;
    logic [3:0] w_next_act;

    if (DEBOUNCE_CYC == 0) begin : g_nodb
        assign w_db = r_raw;
    end else begin : g_db
        localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
        logic [3:0]         r_db;
        logic [3:0][CW-1:0] r_cnt;

        // A bit is accepted on the edge where its mismatch run reaches DEBOUNCE_CYC.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_db  <= '0;
                r_cnt <= '0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (r_raw[b] == r_db[b]) begin
                        r_cnt[b] <= '0;
                    end else if (r_cnt[b] == CW'(DEBOUNCE_CYC - 1)) begin
                        r_db[b]  <= r_raw[b];
                        r_cnt[b] <= '0;
                    end else begin
                        r_cnt[b] <= r_cnt[b] + CW'(1);
                    end
                end
            end
        end
        assign w_db = r_db;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_raw    <= '0;
            r_prev   <= '0;
            r_act    <= '0;
            r_mode_q <= JM_PASS;
        end else begin
            r_raw    <= i_dir;
            r_prev   <= w_db;
            r_act    <= w_next_act;
            r_mode_q <= i_mode;
        end
    end

    // Newest press wins; a released active direction falls back to a held one.
    always_comb begin
        w_allowed  = allowed_mask(r_mode_q);
        w_h        = w_db & w_allowed;
        w_press    = w_h & ~r_prev;
        w_next_act = '0;
        if (i_mode != r_mode_q) begin
            w_next_act = '0;
        end else if (r_mode_q == JM_PASS) begin
            w_next_act = w_db;
        end else if (w_press != 4'b0000) begin
            w_next_act = pick_hi(w_press);
        end else if ((r_act & w_h) != 4'b0000) begin
            w_next_act = r_act;
        end else if (w_h != 4'b0000) begin
            w_next_act = pick_hi(w_h);
        end
    end

    assign o_dir = r_act;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction filter; slices the flat buses into per-player channels.
module joy_dir_filter
    import joy_dir_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned DEBOUNCE_CYC = 0
) (
    input  logic             clk_sys,
    input  logic             reset,
    joy_dir_filter_if.slave  bus
);

    logic [4*NUM_PLAYERS-1:0] w_dir_out;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
        joy_dir_chan #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_chan (
            .clk_sys (clk_sys),
            .reset   (reset),
            .i_dir   (bus.dir_in[4*p +: 4]),
            .i_mode  (joy_mode_e'(bus.mode[2*p +: 2])),
            .o_dir   (w_dir_out[4*p +: 4])
        );
    end

    assign bus.dir_out = w_dir_out;

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench: two filter instances (debounce off / 4 cycles) on the same stimulus, scoreboarded.
module tb_joy_dir_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    joy_dir_filter_if #(.NUM_PLAYERS(2)) if0 ();
    joy_dir_filter_if #(.NUM_PLAYERS(2)) if4 ();

    joy_dir_filter #(.NUM_PLAYERS(2), .DEBOUNCE_CYC(0)) dut0 (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (if0)
    );
    joy_dir_filter #(.NUM_PLAYERS(2), .DEBOUNCE_CYC(4)) dut4 (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (if4)
    );

    typedef struct packed {
        logic [7:0] o0;
        logic [7:0] o4;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state, index [config][player]; config 0 = no debounce, 1 = 4-cycle debounce.
    logic [3:0] m_raw  [2][2];
    logic [3:0] m_db   [2][2];
    logic [3:0] m_prev [2][2];
    logic [3:0] m_act  [2][2];
    logic [1:0] m_mq   [2][2];
    logic [3:0] m_hist [2][2][8];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [3:0] ref_mask(input logic [1:0] m);
        if (m == 2'd2) return 4'b0011;
        if (m == 2'd3) return 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [3:0] ref_hi(input logic [3:0] v);
        for (int b = 3; b >= 0; b--)
            if (v[b]) return 4'(1 << b);
        return 4'b0000;
    endfunction

    // Advance the reference by one clock edge with the given inputs.
    task automatic model_step(input logic [7:0] din, input logic [3:0] md, input logic r);
        logic [3:0] dbc, h, pr, na;
        logic [1:0] mdp;
        int         dc;
        logic       stable;
        for (int k = 0; k < 2; k++) begin
            dc = (k == 0) ? 0 : 4;
            for (int p = 0; p < 2; p++) begin
                if (r) begin
                    m_raw[k][p] = '0; m_db[k][p] = '0; m_prev[k][p] = '0;
                    m_act[k][p] = '0; m_mq[k][p] = '0;
                    for (int i = 0; i < 8; i++) m_hist[k][p][i] = '0;
                end else begin
                    mdp = md[2*p +: 2];
                    dbc = (dc == 0) ? m_raw[k][p] : m_db[k][p];
                    h   = dbc & ref_mask(m_mq[k][p]);
                    pr  = h & ~m_prev[k][p];
                    if (mdp != m_mq[k][p])           na = 4'b0000;
                    else if (m_mq[k][p] == 2'd0)     na = dbc;
                    else if (pr != 0)                na = ref_hi(pr);
                    else if ((m_act[k][p] & h) != 0) na = m_act[k][p];
                    else if (h != 0)                 na = ref_hi(h);
                    else                             na = 4'b0000;
                    // Debounced bit flips once the last dc synced samples all disagree with it.
                    for (int i = 7; i > 0; i--) m_hist[k][p][i] = m_hist[k][p][i-1];
                    m_hist[k][p][0] = m_raw[k][p];
                    if (dc > 0) begin
                        for (int b = 0; b < 4; b++) begin
                            stable = 1'b1;
                            for (int i = 0; i < dc; i++)
                                if (m_hist[k][p][i][b] == m_db[k][p][b]) stable = 1'b0;
                            if (stable) m_db[k][p][b] = m_raw[k][p][b];
                        end
                    end
                    m_prev[k][p] = dbc;
                    m_mq[k][p]   = mdp;
                    m_act[k][p]  = na;
                    m_raw[k][p]  = din[4*p +: 4];
                end
            end
        end
    endtask

    // Apply one cycle of stimulus, queue the expected post-edge outputs, wait for next negedge.
    task automatic cyc(input logic [3:0] d0, input logic [1:0] md0,
                       input logic [3:0] d1, input logic [1:0] md1, input logic r);
        exp_t e;
        if0.dir_in = {d1, d0};
        if4.dir_in = {d1, d0};
        if0.mode   = {md1, md0};
        if4.mode   = {md1, md0};
        rst        = r;
        model_step({d1, d0}, {md1, md0}, r);
        e.o0 = {m_act[0][1], m_act[0][0]};
        e.o4 = {m_act[1][1], m_act[1][0]};
        q.push_back(e);
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops one expectation per edge that has one queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_dut0", if0.dir_out, e.o0);
                chk("sb_dut4", if4.dir_out, e.o4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cd [2];
        logic [1:0] cm [2];
        logic       r;
        if0.dir_in = '0; if4.dir_in = '0;
        if0.mode   = '0; if4.mode   = '0;
        @(negedge clk);
        repeat (2) cyc(4'h0, 2'd1, 4'h0, 2'd1, 1'b1);
        chk("reset_dut0", if0.dir_out, 8'h00);
        chk("reset_dut4", if4.dir_out, 8'h00);
        repeat (2) cyc(4'h0, 2'd1, 4'h0, 2'd1, 1'b0);

        // Four-way: right, then up added, then up released falls back to right.
        cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t1_one_edge", {4'h0, if0.dir_out[3:0]}, 8'h00);
        cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t1_right", {4'h0, if0.dir_out[3:0]}, 8'h01);
        repeat (3) cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        repeat (2) cyc(4'b1001, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t1_up", {4'h0, if0.dir_out[3:0]}, 8'h08);
        repeat (2) cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t1_fallback", {4'h0, if0.dir_out[3:0]}, 8'h01);

        // Simultaneous down+left: down wins.
        repeat (2) cyc(4'h0, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t2_idle", {4'h0, if0.dir_out[3:0]}, 8'h00);
        repeat (2) cyc(4'b0110, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t2_down", {4'h0, if0.dir_out[3:0]}, 8'h04);
        cyc(4'b0110, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t2_hold", {4'h0, if0.dir_out[3:0]}, 8'h04);

        // Two-way horizontal then vertical switch with the input held.
        repeat (3) cyc(4'h0, 2'd2, 4'h0, 2'd1, 1'b0);
        repeat (2) cyc(4'b1010, 2'd2, 4'h0, 2'd1, 1'b0);
        chk("t3_twoh", {4'h0, if0.dir_out[3:0]}, 8'h02);
        cyc(4'b1010, 2'd3, 4'h0, 2'd1, 1'b0);
        chk("t3_switch", {4'h0, if0.dir_out[3:0]}, 8'h00);
        cyc(4'b1010, 2'd3, 4'h0, 2'd1, 1'b0);
        chk("t3_twov", {4'h0, if0.dir_out[3:0]}, 8'h08);

        // Player 0 pass-through diagonal, player 1 four-way independent.
        repeat (3) cyc(4'h0, 2'd0, 4'h0, 2'd1, 1'b0);
        repeat (2) cyc(4'b1001, 2'd0, 4'b0101, 2'd1, 1'b0);
        chk("t4_pass", {4'h0, if0.dir_out[3:0]}, 8'h09);
        chk("t4_p1", {4'h0, if0.dir_out[7:4]}, 8'h04);

        // Debounced instance: 3-cycle glitch rejected, long press after 6 edges.
        repeat (10) cyc(4'h0, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t5_idle", {4'h0, if4.dir_out[3:0]}, 8'h00);
        repeat (3) cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(4'h0, 2'd1, 4'h0, 2'd1, 1'b0);
            chk("t5_glitch", {4'h0, if4.dir_out[3:0]}, 8'h00);
        end
        repeat (5) cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t5_pre", {4'h0, if4.dir_out[3:0]}, 8'h00);
        cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t5_lat6", {4'h0, if4.dir_out[3:0]}, 8'h01);
        repeat (2) cyc(4'b0001, 2'd1, 4'h0, 2'd1, 1'b0);

        // Reset mid-operation with held inputs; partial debounce count must be lost.
        repeat (6) cyc(4'b1000, 2'd1, 4'h0, 2'd1, 1'b0);
        chk("t6_held", {4'h0, if0.dir_out[3:0]}, 8'h08);
        repeat (3) cyc(4'b1000, 2'd1, 4'b0001, 2'd1, 1'b0);
        cyc(4'b1000, 2'd1, 4'b0001, 2'd1, 1'b1);
        chk("t6_rst0", if0.dir_out, 8'h00);
        chk("t6_rst4", if4.dir_out, 8'h00);
        cyc(4'b1000, 2'd1, 4'b0001, 2'd1, 1'b0);
        chk("t6_gap", {4'h0, if0.dir_out[3:0]}, 8'h00);
        cyc(4'b1000, 2'd1, 4'b0001, 2'd1, 1'b0);
        chk("t6_back", {4'h0, if0.dir_out[3:0]}, 8'h08);
        repeat (3) cyc(4'b1000, 2'd1, 4'b0001, 2'd1, 1'b0);
        chk("t6_cnt_pre", {4'h0, if4.dir_out[7:4]}, 8'h00);
        cyc(4'b1000, 2'd1, 4'b0001, 2'd1, 1'b0);
        chk("t6_cnt_lat", {4'h0, if4.dir_out[7:4]}, 8'h01);

        // Randomized traffic against the reference model.
        cd[0] = 4'h0; cd[1] = 4'h0; cm[0] = 2'd1; cm[1] = 2'd1;
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 5) == 0)  cd[p] = 4'($urandom);
                if ($urandom_range(0, 59) == 0) cm[p] = 2'($urandom);
            end
            r = ($urandom_range(0, 199) == 0);
            cyc(cd[0], cm[0], cd[1], cm[1], r);
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
